// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard.
//   FWD_REGFILE  : fwd_sel value meaning "read operand from the register file"
//   operand_e    : operand slot indices (rs1/rs2/rs3)
//   fwd_sel_t    : one operand's forwarding select at the default depth
//   unit_rec_t   : per-unit tracking record (busy flag plus latched destination)
package hazard_pkg;

  localparam int FWD_REGFILE = 0;

  // Widest register index any instance may use; unit records are sized to it
  // so one struct type serves every NREG setting.
  localparam int RW_MAX = 8;

  localparam int NFWD_DEFAULT = 2;
  localparam int SW_DEFAULT   = $clog2(NFWD_DEFAULT + 1);

  typedef enum logic [1:0] {
    OP_RS1 = 2'd0,
    OP_RS2 = 2'd1,
    OP_RS3 = 2'd2
  } operand_e;

  localparam int NUM_OPS = int'(OP_RS3) + 1;

  typedef logic [SW_DEFAULT-1:0] fwd_sel_t;

  typedef struct packed {
    logic              busy;
    logic [RW_MAX-1:0] rd;
    logic              rd_fp;
  } unit_rec_t;

endpackage

// File: rtl/hazard_unit_tracker.sv
// Occupancy tracker for one multi-cycle unit.
//   start      : DP instruction accepted for this unit this cycle
//   start_rd   : destination index of that instruction
//   start_rd_fp: destination lives in the FPU file
//   start_wr   : instruction leaves a pending write (writes rd, rd is not x0)
//   done       : unit_valid completion strobe from the unit
//   busy       : unit occupied
//   en_pulse   : one-cycle start strobe, the cycle after start
//   clr        : completion accepted this cycle; pending bit clears at the edge
//   rec_rd     : latched destination (zero-extended)
//   rec_rd_fp  : latched destination file
module hazard_unit_tracker
  import hazard_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RW-1:0]     start_rd,
  input  logic              start_rd_fp,
  input  logic              start_wr,
  input  logic              done,
  output logic              busy,
  output logic              en_pulse,
  output logic              clr,
  output logic [RW_MAX-1:0] rec_rd,
  output logic              rec_rd_fp
);

  unit_rec_t rec_d, rec_q;
  logic      en_pulse_d, en_pulse_q;

  // A completion only counts while the unit is actually occupied.
  assign clr = done & rec_q.busy;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    rec_d      = rec_q;
    en_pulse_d = start;
    if (start) begin
      rec_d.busy = 1'b1;
      if (start_wr) begin
        rec_d.rd    = RW_MAX'(start_rd);
        rec_d.rd_fp = start_rd_fp;
      end else begin
        // Non-writing ops record integer x0, which is never pending, so the
        // completion clear cannot touch another unit's pending bit.
        rec_d.rd    = '0;
        rec_d.rd_fp = 1'b0;
      end
    end else if (clr) begin
      rec_d.busy = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (!rst_n) begin
      rec_q      <= '0;
      en_pulse_q <= 1'b0;
    end else begin
      rec_q      <= rec_d;
      en_pulse_q <= en_pulse_d;
    end
  end

  assign busy      = rec_q.busy;
  assign en_pulse  = en_pulse_q;
  assign rec_rd    = rec_q.rd;
  assign rec_rd_fp = rec_q.rd_fp;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: forwarding select, issue stall, multi-cycle
// unit tracking and stall performance counter.
//   issue_*       : DP-stage instruction (sources, destination, unit target)
//   fwd_*         : per in-flight stage destination info, index 0 nearest (M)
//   unit_valid    : per-unit one-cycle completion (result written this cycle)
//   stall_issue   : hold DP/F/D, bubble E
//   fwd_sel       : per operand, 0 = regfile, k = stage k-1
//   unit_en_pulse : per-unit one-cycle start strobe
//   unit_busy     : per-unit occupancy
//   stall_cycles  : saturating count of stalled cycles
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int NFWD  = 2,
  parameter int NUNIT = 2,
  parameter int RW    = $clog2(NREG),
  parameter int SW    = $clog2(NFWD + 1),
  parameter int UW    = (NUNIT > 1) ? $clog2(NUNIT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic                 issue_flush,
  input  logic [NUM_OPS*RW-1:0] issue_rs,
  input  logic [NUM_OPS-1:0]   issue_rs_used,
  input  logic [NUM_OPS-1:0]   issue_rs_fp,
  input  logic [RW-1:0]        issue_rd,
  input  logic                 issue_rd_fp,
  input  logic                 issue_reg_write,
  input  logic                 issue_multi,
  input  logic [UW-1:0]        issue_unit,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RW-1:0]   fwd_rd,
  input  logic [NFWD-1:0]      fwd_fp,
  input  logic [NFWD-1:0]      fwd_ready,
  input  logic [NUNIT-1:0]     unit_valid,
  output logic                 stall_issue,
  output logic [NUM_OPS*SW-1:0] fwd_sel,
  output logic [NUNIT-1:0]     unit_en_pulse,
  output logic [NUNIT-1:0]     unit_busy,
  output logic [31:0]          stall_cycles
);

  // Pending-write bits, [0] = integer file, [1] = FPU file.
  logic [1:0][NREG-1:0] pending_d, pending_q;
  logic [31:0]          stall_cycles_d, stall_cycles_q;

  logic [NUM_OPS-1:0]            rs_is_x0;
  logic [NUM_OPS-1:0][NFWD-1:0]  op_match;
  logic                          load_use, raw, waw, structural;
  logic                          accept, rd_writes;
  logic [NUNIT-1:0]              unit_start, unit_clr;
  logic [RW_MAX-1:0]             unit_rd [NUNIT];
  logic [NUNIT-1:0]              unit_rd_fp;

  // ---------------------------------------------------------------- matching
  for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
    assign rs_is_x0[k] = ~issue_rs_fp[k] & (issue_rs[k*RW +: RW] == '0);
    for (genvar s = 0; s < NFWD; s++) begin : g_stage
      assign op_match[k][s] = fwd_valid[s] & issue_rs_used[k] & ~rs_is_x0[k]
                            & (fwd_rd[s*RW +: RW] == issue_rs[k*RW +: RW])
                            & (fwd_fp[s] == issue_rs_fp[k]);
    end
  end

  // Priority encode per operand: the nearest matching stage wins, and only
  // its readiness matters for the load-use check.
  always_comb begin
    logic found;
    found    = 1'b0;
    fwd_sel  = {NUM_OPS{SW'(FWD_REGFILE)}};
    load_use = 1'b0;
    raw      = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      found = 1'b0;
      for (int s = 0; s < NFWD; s++) begin
        if (!found && op_match[k][s]) begin
          found                = 1'b1;
          fwd_sel[k*SW +: SW]  = SW'(s + 1);
          if (!fwd_ready[s]) load_use = 1'b1;
        end
      end
      if (issue_rs_used[k] && pending_q[issue_rs_fp[k]][issue_rs[k*RW +: RW]]) raw = 1'b1;
    end
    if (!issue_valid) fwd_sel = {NUM_OPS{SW'(FWD_REGFILE)}};
  end

  // ------------------------------------------------------------------ stall
  assign rd_writes = issue_reg_write & ~(~issue_rd_fp & (issue_rd == '0));
  assign waw       = rd_writes & pending_q[issue_rd_fp][issue_rd];

  always_comb begin
    structural = 1'b0;
    for (int u = 0; u < NUNIT; u++) begin
      if (issue_multi && issue_unit == UW'(u) && unit_busy[u]) structural = 1'b1;
    end
  end

  assign stall_issue = issue_valid & ~issue_flush & (load_use | raw | waw | structural);
  assign accept      = issue_valid & ~issue_flush & ~stall_issue;

  // ------------------------------------------------------------------ units
  for (genvar u = 0; u < NUNIT; u++) begin : g_unit
    assign unit_start[u] = accept & issue_multi & (issue_unit == UW'(u));

    hazard_unit_tracker #(.RW(RW)) u_tracker (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (unit_start[u]),
      .start_rd    (issue_rd),
      .start_rd_fp (issue_rd_fp),
      .start_wr    (rd_writes),
      .done        (unit_valid[u]),
      .busy        (unit_busy[u]),
      .en_pulse    (unit_en_pulse[u]),
      .clr         (unit_clr[u]),
      .rec_rd      (unit_rd[u]),
      .rec_rd_fp   (unit_rd_fp[u])
    );
  end

  // --------------------------------------------------------- pending bits
  // Set and clear of the same bit in one cycle is excluded by the WAW stall,
  // so the order below only matters for readability.
  always_comb begin
    pending_d = pending_q;
    for (int u = 0; u < NUNIT; u++) begin
      for (int i = 0; i < NREG; i++) begin
        if (unit_clr[u] && unit_rd[u] == RW_MAX'(i)) pending_d[unit_rd_fp[u]][i] = 1'b0;
      end
    end
    if (accept && issue_multi && rd_writes) pending_d[issue_rd_fp][issue_rd] = 1'b1;
  end

  // ---------------------------------------------------------------- counter
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_issue && stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: pending bits are discrete flops, not a RAM, so they take the async
    // reset and a mid-operation reset leaves no stale hazards behind.
    if (!rst_n) begin
      pending_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      pending_q      <= pending_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vectors with literal
// expectations, plus a rule-level scoreboard compared on every falling edge.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NREG = 32, NFWD = 2, NUNIT = 2, RW = 5, SW = 2, UW = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                issue_valid, issue_flush;
  logic [3*RW-1:0]     issue_rs;
  logic [2:0]          issue_rs_used, issue_rs_fp;
  logic [RW-1:0]       issue_rd;
  logic                issue_rd_fp, issue_reg_write, issue_multi;
  logic [UW-1:0]       issue_unit;
  logic [NFWD-1:0]     fwd_valid, fwd_fp, fwd_ready;
  logic [NFWD*RW-1:0]  fwd_rd;
  logic [NUNIT-1:0]    unit_valid;
  logic                stall_issue;
  logic [3*SW-1:0]     fwd_sel;
  logic [NUNIT-1:0]    unit_en_pulse, unit_busy;
  logic [31:0]         stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard #(.NREG(NREG), .NFWD(NFWD), .NUNIT(NUNIT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .issue_flush     (issue_flush),
    .issue_rs        (issue_rs),
    .issue_rs_used   (issue_rs_used),
    .issue_rs_fp     (issue_rs_fp),
    .issue_rd        (issue_rd),
    .issue_rd_fp     (issue_rd_fp),
    .issue_reg_write (issue_reg_write),
    .issue_multi     (issue_multi),
    .issue_unit      (issue_unit),
    .fwd_valid       (fwd_valid),
    .fwd_rd          (fwd_rd),
    .fwd_fp          (fwd_fp),
    .fwd_ready       (fwd_ready),
    .unit_valid      (unit_valid),
    .stall_issue     (stall_issue),
    .fwd_sel         (fwd_sel),
    .unit_en_pulse   (unit_en_pulse),
    .unit_busy       (unit_busy),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  // Scoreboard state: which registers await a unit result, and what each
  // unit is doing. Outputs follow directly from the hazard rules.
  bit     m_pend [2][NREG];
  bit     m_busy [NUNIT];
  int     m_rd   [NUNIT];
  bit     m_fp   [NUNIT];
  bit     m_wr   [NUNIT];
  bit     m_en   [NUNIT];
  longint m_cnt;
  logic       exp_stall;
  logic [5:0] exp_sel;

  function automatic void model_reset();
    for (int f = 0; f < 2; f++) for (int r = 0; r < NREG; r++) m_pend[f][r] = 1'b0;
    for (int u = 0; u < NUNIT; u++) begin
      m_busy[u] = 0; m_rd[u] = 0; m_fp[u] = 0; m_wr[u] = 0; m_en[u] = 0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_eval();
    bit       hazard;
    fwd_sel_t sel;
    int       rs;
    bit       fp;
    hazard  = 0;
    exp_sel = '0;
    for (int k = 0; k < 3; k++) begin
      rs  = int'(issue_rs[k*RW +: RW]);
      fp  = issue_rs_fp[k];
      sel = fwd_sel_t'(FWD_REGFILE);
      if (issue_rs_used[k] && !(!fp && rs == 0)) begin
        for (int s = 0; s < NFWD; s++) begin
          if (sel == 0 && fwd_valid[s] && int'(fwd_rd[s*RW +: RW]) == rs && fwd_fp[s] == fp) begin
            sel = fwd_sel_t'(s + 1);
            if (!fwd_ready[s]) hazard = 1;
          end
        end
      end
      if (issue_rs_used[k] && m_pend[fp][rs]) hazard = 1;
      if (issue_valid) exp_sel[k*SW +: SW] = sel;
    end
    if (issue_reg_write && !(!issue_rd_fp && issue_rd == 0) && m_pend[issue_rd_fp][issue_rd]) hazard = 1;
    if (issue_multi && m_busy[issue_unit]) hazard = 1;
    exp_stall = issue_valid && !issue_flush && hazard;
  endfunction

  function automatic void model_step();
    bit accept;
    int u;
    accept = issue_valid && !issue_flush && !exp_stall;
    for (int i = 0; i < NUNIT; i++) begin
      m_en[i] = 0;
      if (unit_valid[i] && m_busy[i]) begin
        m_busy[i] = 0;
        if (m_wr[i]) m_pend[m_fp[i]][m_rd[i]] = 0;
      end
    end
    if (accept && issue_multi) begin
      u         = int'(issue_unit);
      m_busy[u] = 1;
      m_en[u]   = 1;
      m_rd[u]   = int'(issue_rd);
      m_fp[u]   = issue_rd_fp;
      m_wr[u]   = issue_reg_write && !(!issue_rd_fp && issue_rd == 0);
      if (m_wr[u]) m_pend[m_fp[u]][m_rd[u]] = 1;
    end
    if (exp_stall && m_cnt != 64'hFFFF_FFFF) m_cnt++;
  endfunction

  // Compare process: inputs change just after the rising edge, so the
  // falling edge sees settled outputs for the cycle about to be clocked.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      check("rst_busy", 32'(unit_busy), 32'd0);
      check("rst_en_pulse", 32'(unit_en_pulse), 32'd0);
      check("rst_stall_cycles", stall_cycles, 32'd0);
    end else begin
      model_eval();
      check("model_stall_issue", 32'(stall_issue), 32'(exp_stall));
      check("model_fwd_sel", 32'(fwd_sel), 32'(exp_sel));
      check("model_unit_busy", 32'(unit_busy), 32'({m_busy[1], m_busy[0]}));
      check("model_en_pulse", 32'(unit_en_pulse), 32'({m_en[1], m_en[0]}));
      check("model_stall_cycles", stall_cycles, m_cnt[31:0]);
      model_step();
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic idle();
    issue_valid = 0; issue_flush = 0; issue_rs = '0; issue_rs_used = '0;
    issue_rs_fp = '0; issue_rd = '0; issue_rd_fp = 0; issue_reg_write = 0;
    issue_multi = 0; issue_unit = '0; fwd_valid = '0; fwd_rd = '0;
    fwd_fp = '0; fwd_ready = '0; unit_valid = '0;
  endtask

  task automatic set_src(input int k, input int rs, input bit fp);
    issue_rs[k*RW +: RW] = RW'(rs);
    issue_rs_used[k]     = 1'b1;
    issue_rs_fp[k]       = fp;
  endtask

  task automatic set_fwd(input int s, input int rd, input bit fp, input bit ready);
    fwd_valid[s]       = 1'b1;
    fwd_rd[s*RW +: RW] = RW'(rd);
    fwd_fp[s]          = fp;
    fwd_ready[s]       = ready;
  endtask

  task automatic set_multi(input int unit, input int rd, input bit fp, input bit wr);
    issue_multi     = 1'b1;
    issue_unit      = UW'(unit);
    issue_rd        = RW'(rd);
    issue_rd_fp     = fp;
    issue_reg_write = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(unit_busy), 32'd0);
    check("reset_en_pulse", 32'(unit_en_pulse), 32'd0);
    check("reset_stall_cycles", stall_cycles, 32'd0);
    check("reset_idle_no_stall", 32'(stall_issue), 32'd0);
    rst_n = 1'b1;

    // Forwarding priority: nearest stage wins; unready nearest stage stalls.
    set_fwd(0, 5, 0, 1); set_fwd(1, 5, 0, 1);
    issue_valid = 1; set_src(int'(OP_RS1), 5, 0);
    #1 check("prio_sel_m", 32'(fwd_sel), 32'h01);
    check("prio_no_stall", 32'(stall_issue), 32'd0);
    fwd_ready[0] = 1'b0;
    #1 check("load_use_stall", 32'(stall_issue), 32'd1);
    tick();

    // x0 never forwards, f0 does.
    idle(); set_fwd(0, 0, 0, 1); issue_valid = 1; set_src(int'(OP_RS1), 0, 0);
    #1 check("x0_no_fwd", 32'(fwd_sel), 32'h00);
    fwd_fp[0] = 1'b1; issue_rs_fp[0] = 1'b1;
    #1 check("f0_fwd", 32'(fwd_sel), 32'h01);
    tick();

    // RAW on the slow FPU.
    idle(); issue_valid = 1; set_multi(1, 3, 1, 1);
    #1 check("fdiv_accept", 32'(stall_issue), 32'd0);
    tick();
    idle();
    check("fdiv_en_pulse", 32'(unit_en_pulse), 32'b10);
    check("fdiv_busy", 32'(unit_busy), 32'b10);
    issue_valid = 1; set_src(int'(OP_RS2), 3, 1);
    #1 check("raw_f3_stall", 32'(stall_issue), 32'd1);
    tick();
    check("en_pulse_one_cycle", 32'(unit_en_pulse), 32'b00);
    tick(); tick();
    unit_valid = 2'b10;
    #1 check("raw_same_cycle_stall", 32'(stall_issue), 32'd1);
    tick();
    unit_valid = 2'b00;
    #1 check("raw_released", 32'(stall_issue), 32'd0);
    check("raw_from_regfile", 32'(fwd_sel), 32'h00);
    check("fdiv_idle", 32'(unit_busy), 32'b00);
    tick();

    // Structural and WAW.
    idle(); issue_valid = 1; set_multi(0, 7, 0, 1);
    tick();
    idle();
    check("fadd_busy", 32'(unit_busy), 32'b01);
    issue_valid = 1; set_multi(0, 8, 0, 1);
    #1 check("structural_stall", 32'(stall_issue), 32'd1);
    idle(); issue_valid = 1; set_multi(1, 7, 0, 1);
    #1 check("waw_stall", 32'(stall_issue), 32'd1);
    idle(); issue_valid = 1; set_multi(1, 9, 0, 1);
    #1 check("independent_accept", 32'(stall_issue), 32'd0);
    tick();
    idle();
    check("both_busy", 32'(unit_busy), 32'b11);
    check("unit1_en_pulse", 32'(unit_en_pulse), 32'b10);

    // Flush kills only the DP instruction.
    issue_valid = 1; set_multi(0, 10, 0, 1); issue_flush = 1;
    #1 check("flush_no_stall", 32'(stall_issue), 32'd0);
    tick();
    idle();
    check("flush_no_en_pulse", 32'(unit_en_pulse), 32'b00);
    check("flush_busy_kept", 32'(unit_busy), 32'b11);
    issue_valid = 1; set_src(int'(OP_RS1), 10, 0);
    #1 check("flush_no_pending", 32'(stall_issue), 32'd0);
    idle(); unit_valid = 2'b01;
    tick();
    unit_valid = 2'b00;
    check("inflight_cleared", 32'(unit_busy), 32'b10);
    issue_valid = 1; set_src(int'(OP_RS3), 7, 0);
    #1 check("x7_pending_cleared", 32'(stall_issue), 32'd0);
    idle(); unit_valid = 2'b01;
    tick();
    unit_valid = 2'b00;
    check("spurious_valid_ignored", 32'(unit_busy), 32'b10);

    // Asynchronous reset with a unit busy and a pending bit set.
    issue_valid = 1; set_src(int'(OP_RS1), 9, 0);
    #1 check("raw_x9_stall", 32'(stall_issue), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_busy", 32'(unit_busy), 32'd0);
    check("async_rst_pending", 32'(stall_issue), 32'd0);
    check("async_rst_counter", stall_cycles, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Ten load-use stalled cycles.
    idle(); set_fwd(0, 5, 0, 0); issue_valid = 1; set_src(int'(OP_RS1), 5, 0);
    repeat (10) tick();
    idle();
    check("stall_cycles_10", stall_cycles, 32'd10);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the v2 forwarding/stall logic, sitting between the dispatch (DP) stage and the execute/multi-cycle units. It tracks pending writes of multi-cycle units (FPU fast/slow, cache) per register in both the integer and FPU files, and selects forwarding sources across a configurable number of in-flight stages. It also generates issue stall, per-unit enable pulses and a stall performance counter.

## Interface
- NREG, 32, registers per file; RW = $clog2(NREG)
- NFWD, 2, forwarding stages; index 0 = nearest (M), 1 = W, …
- NUNIT, 2, multi-cycle units; index 0 = fast FPU, 1 = slow FPU
- SW = $clog2(NFWD+1), forwarding-select width
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- issue_valid  in  1  DP holds an instruction
- issue_flush  in  1  kill DP instruction this cycle
- issue_rs  in  3×RW  source indices rs1, rs2, rs3
- issue_rs_used  in  3  operand k is read
- issue_rs_fp  in  3  operand k is read from the FPU file
- issue_rd  in  RW  destination
- issue_rd_fp  in  1  destination is in the FPU file
- issue_reg_write  in  1  instruction writes rd
- issue_multi  in  1  instruction goes to a multi-cycle unit
- issue_unit  in  $clog2(NUNIT)  target unit when issue_multi
- fwd_valid  in  NFWD  stage holds a register-writing instruction
- fwd_rd  in  NFWD×RW  stage destination
- fwd_fp  in  NFWD  stage destination is in the FPU file
- fwd_ready  in  NFWD  stage result is available (0 for a load in M)
- unit_valid  in  NUNIT  one-cycle completion; result is written to the regfile in this cycle
- stall_issue  out  1  hold DP/F/D, bubble E
- fwd_sel  out  3×SW  per operand: 0 = regfile, k = stage k-1
- unit_en_pulse  out  NUNIT  one-cycle start strobe
- unit_busy  out  NUNIT  unit occupied
- stall_cycles  out  32  saturating count of stalled cycles

## Operation
- Operand match in stage s: fwd_valid[s] & fwd_rd[s]==rs & fwd_fp[s]==rs_fp & issue_rs_used & ~(~rs_fp & rs==0). An integer x0 never matches; f0 is a real register.
- fwd_sel[k] is the lowest matching s, plus 1. With no match it is 0. Only the nearest match is considered.
- stall_issue = issue_valid & ~issue_flush & (any condition below). It is combinational from inputs and registered state:
  - load-use: the nearest matching stage has fwd_ready=0.
  - RAW: pending[fp][rs] is set for any used operand.
  - WAW: issue_reg_write & pending[rd_fp][rd]. This check is skipped for integer rd==0.
  - structural: issue_multi & unit_busy[issue_unit].
- accept = issue_valid & ~issue_flush & ~stall_issue.
- When accept & issue_multi, the following happen in the next cycle:
  - unit_busy[u] is set.
  - unit_en_pulse[u] is high for exactly one cycle.
  - The unit latches rd and rd_fp.
  - If issue_reg_write is set and rd is not integer x0, the pending bit for that rd is set.
- On unit_valid[u] with busy[u], the following happen in the next cycle:
  - busy[u] clears.
  - The latched pending bit clears.
  - unit_valid while not busy is ignored.
- A unit completing in the same cycle as a dependent issue still stalls that cycle; the dependent issue proceeds the next cycle from the regfile.
- A same-cycle completion on unit u and accept to unit u cannot occur, because the structural stall holds the issue.
- Set and clear of the same pending bit in one cycle cannot occur, because of the WAW stall.
- issue_flush affects only the DP instruction. Units already in flight complete and clear normally.
- stall_cycles increments each cycle stall_issue=1 and saturates at 0xFFFF_FFFF.

## Timing
- Reset values: pending all 0, unit_busy 0, unit_en_pulse 0, stall_cycles 0. stall_issue=0 and fwd_sel=0 while issue_valid=0.
- Latency: accept to unit_en_pulse and unit_busy is 1 cycle. unit_valid to busy/pending clear is 1 cycle.
- Minimum back-to-back issue to one unit: the cycle after busy clears.
- rst assertion mid-operation clears all state immediately. Units must be reset by the same rst.

## Structure
- hazard_pkg holds:
  - constants FWD_REGFILE=0
  - operand enum OP_RS1/OP_RS2/OP_RS3
  - typedef fwd_sel_t
  - typedef unit_rec_t {busy, rd, rd_fp}
- Sub-module hazard_unit_tracker, instantiated NUNIT times, holds busy, the rd record, the en pulse flop and the clear strobe.
- The top holds the 2×NREG pending bits, the forwarding priority encoders and the counter.

## Test plan
- Priority: M rd=5 int ready, W rd=5 int, issue rs1=5 used → fwd_sel[0]=1, no stall. With M fwd_ready=0 → stall_issue=1.
- x0/f0: M rd=0 int, issue rs1=0 int → fwd_sel=0. M rd=0 fp, issue rs1=0 fp → fwd_sel=1.
- RAW on slow FPU:
  - Issue rd=f3 to unit 1 → en_pulse[1] for one cycle, pending f3 set.
  - Issue reading f3 stalls until the cycle after unit_valid[1], then fwd_sel=0.
- Structural/WAW:
  - A second issue to busy unit 0 stalls.
  - An issue to unit 1 with rd equal to unit 0's pending rd stalls.
  - An independent issue to unit 1 is accepted.
- Flush: issue_flush with a stall condition present → stall_issue=0, no en_pulse, no pending change. An in-flight unit still clears on unit_valid.
- Reset mid-busy, counter: assert rst with busy and pending set → all cleared asynchronously. Ten stalled cycles → stall_cycles=10.
